// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline constants for the forwarding / load-use hazard unit.
package fwd_hazard_unit_pkg;

   localparam int REG_W       = 5;
   localparam int DEF_DEPTH   = 2;
   localparam int DEF_NUM_SRC = 2;

   // Forwarding select encoding: 0 reads the register file, k selects stage k.
   localparam int SEL_RF = 0;

   function automatic int sel_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and hazard-unit response bundle.
interface fwd_hazard_unit_if #(
   parameter int NUM_SRC = fwd_hazard_unit_pkg::DEF_NUM_SRC,
   parameter int REG_W   = fwd_hazard_unit_pkg::REG_W,
   parameter int SEL_W   = fwd_hazard_unit_pkg::sel_width(fwd_hazard_unit_pkg::DEF_DEPTH)
);

   logic                     id_valid;
   logic [NUM_SRC*REG_W-1:0] id_src;
   logic [NUM_SRC-1:0]       id_src_used;
   logic [REG_W-1:0]         id_wn;
   logic                     id_we;
   logic                     id_load;
   logic                     hold;
   logic                     flush;
   logic                     stall;
   logic [NUM_SRC*SEL_W-1:0] f_src;
   logic [15:0]              stall_cnt;

   modport master (
      output id_valid, id_src, id_src_used, id_wn, id_we, id_load, hold, flush,
      input  stall, f_src, stall_cnt
   );

   modport slave (
      input  id_valid, id_src, id_src_used, id_wn, id_we, id_load, hold, flush,
      output stall, f_src, stall_cnt
   );

endinterface

// File: rtl/fwd_hazard_unit_fwd_match.sv
// Priority match of one EX source register against producer stages P[1..DEPTH].
module fwd_match #(
   parameter int DEPTH = fwd_hazard_unit_pkg::DEF_DEPTH,
   parameter int REG_W = fwd_hazard_unit_pkg::REG_W,
   parameter int SEL_W = fwd_hazard_unit_pkg::sel_width(fwd_hazard_unit_pkg::DEF_DEPTH)
) (
   input  logic                        en_i,
   input  logic [REG_W-1:0]            src_i,
   input  logic [DEPTH-1:0]            p_valid_i,
   input  logic [DEPTH-1:0]            p_we_i,
   input  logic [DEPTH-1:0][REG_W-1:0] p_wn_i,
   output logic [SEL_W-1:0]            sel_o
);
   import fwd_hazard_unit_pkg::*;

   logic [SEL_W-1:0] sel_s;

   // Scan farthest to nearest so the nearest matching stage overwrites the rest.
   always_comb begin
      sel_s = SEL_W'(SEL_RF);
      for (int k = DEPTH - 1; k >= 0; k--) begin
         sel_s = (en_i && p_valid_i[k] && p_we_i[k] &&
                  (p_wn_i[k] != {REG_W{1'b0}}) && (p_wn_i[k] == src_i))
                 ? SEL_W'(k + 1) : sel_s;
      end
   end

   assign sel_o = sel_s;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks EX and post-EX producers; emits operand forwarding selects and load-use stall.
module fwd_hazard_unit #(
   parameter int NUM_SRC = fwd_hazard_unit_pkg::DEF_NUM_SRC,
   parameter int DEPTH   = fwd_hazard_unit_pkg::DEF_DEPTH,
   parameter int REG_W   = fwd_hazard_unit_pkg::REG_W
) (
   input logic              clk,
   input logic              rst,
   fwd_hazard_unit_if.slave bus
);
   import fwd_hazard_unit_pkg::*;

   localparam int SEL_W = $clog2(DEPTH + 1);

   logic                        ex_valid_q,    ex_valid_d;
   logic [REG_W-1:0]            ex_wn_q,       ex_wn_d;
   logic                        ex_we_q,       ex_we_d;
   logic                        ex_load_q,     ex_load_d;
   logic [NUM_SRC*REG_W-1:0]    ex_src_q,      ex_src_d;
   logic [NUM_SRC-1:0]          ex_src_used_q, ex_src_used_d;
   logic [DEPTH-1:0]            p_valid_q,     p_valid_d;
   logic [DEPTH-1:0]            p_we_q,        p_we_d;
   logic [DEPTH-1:0][REG_W-1:0] p_wn_q,        p_wn_d;
   logic [15:0]                 stall_cnt_q,   stall_cnt_d;

   logic                        advance_s;
   logic                        src_hit_s;
   logic                        stall_s;
   logic [NUM_SRC*SEL_W-1:0]    f_src_s;

   assign advance_s = !bus.hold;

   // Load-use hazard: the EX load's destination is read by the instruction in ID.
   always_comb begin
      src_hit_s = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src_hit_s = src_hit_s |
                     (bus.id_src_used[i] & (bus.id_src[i*REG_W +: REG_W] == ex_wn_q));
      end
      stall_s = bus.id_valid & ex_valid_q & ex_we_q & ex_load_q &
                (ex_wn_q != {REG_W{1'b0}}) & src_hit_s;
   end

   // Pipeline shift; a stalled or flushed slot enters EX as a bubble.
   always_comb begin
      ex_valid_d    = ex_valid_q;
      ex_wn_d       = ex_wn_q;
      ex_we_d       = ex_we_q;
      ex_load_d     = ex_load_q;
      ex_src_d      = ex_src_q;
      ex_src_used_d = ex_src_used_q;
      p_valid_d     = p_valid_q;
      p_we_d        = p_we_q;
      p_wn_d        = p_wn_q;
      if (advance_s) begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            p_valid_d[k] = p_valid_q[k-1];
            p_we_d[k]    = p_we_q[k-1];
            p_wn_d[k]    = p_wn_q[k-1];
         end
         p_valid_d[0]  = ex_valid_q;
         p_we_d[0]     = ex_we_q;
         p_wn_d[0]     = ex_wn_q;
         ex_valid_d    = bus.id_valid & ~stall_s & ~bus.flush;
         ex_wn_d       = bus.id_wn;
         ex_we_d       = bus.id_we;
         ex_load_d     = bus.id_load;
         ex_src_d      = bus.id_src;
         ex_src_used_d = bus.id_src_used;
      end else begin
         ex_valid_d    = ex_valid_q & ~bus.flush;
      end
   end

   // Saturating stall-cycle counter.
   always_comb begin
      if (stall_s && advance_s && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ex_valid_q    <= 1'b0;
         ex_wn_q       <= {REG_W{1'b0}};
         ex_we_q       <= 1'b0;
         ex_load_q     <= 1'b0;
         ex_src_q      <= {(NUM_SRC*REG_W){1'b0}};
         ex_src_used_q <= {NUM_SRC{1'b0}};
         p_valid_q     <= {DEPTH{1'b0}};
         p_we_q        <= {DEPTH{1'b0}};
         p_wn_q        <= {(DEPTH*REG_W){1'b0}};
         stall_cnt_q   <= 16'd0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_wn_q       <= ex_wn_d;
         ex_we_q       <= ex_we_d;
         ex_load_q     <= ex_load_d;
         ex_src_q      <= ex_src_d;
         ex_src_used_q <= ex_src_used_d;
         p_valid_q     <= p_valid_d;
         p_we_q        <= p_we_d;
         p_wn_q        <= p_wn_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_match
      fwd_match #(
         .DEPTH (DEPTH),
         .REG_W (REG_W),
         .SEL_W (SEL_W)
      ) u_match (
         .en_i      (ex_valid_q & ex_src_used_q[g]),
         .src_i     (ex_src_q[g*REG_W +: REG_W]),
         .p_valid_i (p_valid_q),
         .p_we_i    (p_we_q),
         .p_wn_i    (p_wn_q),
         .sel_o     (f_src_s[g*SEL_W +: SEL_W])
      );
   end

   assign bus.stall     = stall_s;
   assign bus.f_src     = f_src_s;
   assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scenarios for fwd_hazard_unit (NUM_SRC=2, DEPTH=2, REG_W=5).
module tb_fwd_hazard_unit;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   fwd_hazard_unit_if #(.NUM_SRC(2), .REG_W(5), .SEL_W(2)) bus ();

   fwd_hazard_unit #(.NUM_SRC(2), .DEPTH(2), .REG_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] wn,
                         input logic we, input logic ld);
      bus.id_valid    = v;
      bus.id_src      = {s1, s0};
      bus.id_src_used = used;
      bus.id_wn       = wn;
      bus.id_we       = we;
      bus.id_load     = ld;
      #1;
   endtask

   task automatic drain();
      set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.hold = 1'b0;
      bus.flush = 1'b0;
      set_id(1'b1, 5'd2, 5'd2, 2'b11, 5'd2, 1'b1, 1'b1);
      repeat (2) tick();
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %0b want 0", bus.stall); end
      n_cmp++; if (bus.f_src !== 4'b0000) begin n_err++; $display("FAIL rst_fsrc: got %b want 0000", bus.f_src); end
      n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", bus.stall_cnt); end
      rst = 1'b1;
      drain();
   endtask

   task automatic test_fwd_ex_mem();
      set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd3, 5'd5, 2'b11, 5'd4, 1'b1, 1'b0);
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL exmem_nostall: got %0b want 0", bus.stall); end
      tick();
      n_cmp++; if (bus.f_src !== 4'b0001) begin n_err++; $display("FAIL exmem_fsrc: got %b want 0001", bus.f_src); end
      drain();
   endtask

   task automatic test_fwd_wb();
      set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
      tick();
      set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      tick();
      set_id(1'b1, 5'd3, 5'd3, 2'b11, 5'd6, 1'b1, 1'b0);
      tick();
      n_cmp++; if (bus.f_src !== 4'b1010) begin n_err++; $display("FAIL wb_fsrc: got %b want 1010", bus.f_src); end
      drain();
   endtask

   task automatic test_load_use();
      set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd2, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0);
      n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %0b want 1", bus.stall); end
      n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_err++; $display("FAIL lu_cnt0: got %0d want 0", bus.stall_cnt); end
      tick();
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL lu_one_cycle: got %0b want 0", bus.stall); end
      n_cmp++; if (bus.stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_cnt1: got %0d want 1", bus.stall_cnt); end
      n_cmp++; if (bus.f_src !== 4'b0000) begin n_err++; $display("FAIL lu_bubble: got %b want 0000", bus.f_src); end
      tick();
      n_cmp++; if (bus.f_src !== 4'b0010) begin n_err++; $display("FAIL lu_fsrc: got %b want 0010", bus.f_src); end
      drain();
   endtask

   task automatic test_reg_zero();
      set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd8, 1'b1, 1'b0);
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL r0_stall: got %0b want 0", bus.stall); end
      tick();
      n_cmp++; if (bus.f_src !== 4'b0000) begin n_err++; $display("FAIL r0_fsrc: got %b want 0000", bus.f_src); end
      set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd8, 1'b1, 1'b0);
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL r0_load_stall: got %0b want 0", bus.stall); end
      drain();
   endtask

   task automatic test_src_unused();
      set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd3, 5'd3, 2'b10, 5'd9, 1'b1, 1'b0);
      tick();
      n_cmp++; if (bus.f_src !== 4'b0100) begin n_err++; $display("FAIL unused_fsrc: got %b want 0100", bus.f_src); end
      drain();
   endtask

   task automatic test_nearest_hold();
      set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd4, 5'd5, 2'b11, 5'd3, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd3, 5'd3, 2'b11, 5'd8, 1'b1, 1'b0);
      tick();
      n_cmp++; if (bus.f_src !== 4'b0101) begin n_err++; $display("FAIL nearest_fsrc: got %b want 0101", bus.f_src); end
      bus.hold = 1'b1;
      set_id(1'b1, 5'd8, 5'd8, 2'b11, 5'd9, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++; if (bus.f_src !== 4'b0101) begin n_err++; $display("FAIL hold_fsrc[%0d]: got %b want 0101", c, bus.f_src); end
      end
      bus.hold = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      tick();
      n_cmp++; if (bus.f_src !== 4'b0000) begin n_err++; $display("FAIL post_hold_fsrc: got %b want 0000", bus.f_src); end
      drain();
   endtask

   task automatic test_stall_hold();
      set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd2, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0);
      bus.hold = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL sh_stall[%0d]: got %0b want 1", c, bus.stall); end
         n_cmp++; if (bus.stall_cnt !== 16'd1) begin n_err++; $display("FAIL sh_cnt[%0d]: got %0d want 1", c, bus.stall_cnt); end
      end
      bus.hold = 1'b0;
      tick();
      n_cmp++; if (bus.stall_cnt !== 16'd2) begin n_err++; $display("FAIL sh_cnt_rel: got %0d want 2", bus.stall_cnt); end
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL sh_stall_rel: got %0b want 0", bus.stall); end
      drain();
   endtask

   task automatic test_flush();
      set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd2, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0);
      n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL fl_stall_pre: got %0b want 1", bus.stall); end
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      #1;
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL fl_stall_post: got %0b want 0", bus.stall); end
      n_cmp++; if (bus.stall_cnt !== 16'd3) begin n_err++; $display("FAIL fl_cnt: got %0d want 3", bus.stall_cnt); end
      tick();
      n_cmp++; if (bus.f_src !== 4'b0010) begin n_err++; $display("FAIL fl_fsrc: got %b want 0010", bus.f_src); end
      drain();
      // Flush while frozen kills the load in place, so it never reaches P[1].
      set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd2, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0);
      bus.hold = 1'b1;
      bus.flush = 1'b1;
      tick();
      bus.hold = 1'b0;
      bus.flush = 1'b0;
      #1;
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL flh_stall: got %0b want 0", bus.stall); end
      n_cmp++; if (bus.stall_cnt !== 16'd3) begin n_err++; $display("FAIL flh_cnt: got %0d want 3", bus.stall_cnt); end
      tick();
      n_cmp++; if (bus.f_src !== 4'b0000) begin n_err++; $display("FAIL flh_fsrc: got %b want 0000", bus.f_src); end
      drain();
   endtask

   task automatic test_reset_mid_stall();
      set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd2, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0);
      n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL rms_stall_pre: got %0b want 1", bus.stall); end
      rst = 1'b0;
      bus.hold = 1'b1;
      tick();
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL rms_stall: got %0b want 0", bus.stall); end
      n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_err++; $display("FAIL rms_cnt: got %0d want 0", bus.stall_cnt); end
      n_cmp++; if (bus.f_src !== 4'b0000) begin n_err++; $display("FAIL rms_fsrc: got %b want 0000", bus.f_src); end
      rst = 1'b1;
      bus.hold = 1'b0;
      drain();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_fwd_ex_mem();
      test_fwd_wb();
      test_load_use();
      test_reg_zero();
      test_src_unused();
      test_nearest_hold();
      test_stall_hold();
      test_flush();
      test_reset_mid_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2; source operands per instruction.
REQ-002 SHALL have parameter DEPTH, default 2; forwarding stages after EX (1 = EX/MEM, DEPTH = WB).
REQ-003 SHALL have parameter REG_W, default 5; register-number width.
REQ-004 SHALL have derived localparam SEL_W = clog2(DEPTH+1); forwarding-select width.
REQ-005 SHALL have one clock, and reset is synchronous and active-low: clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-low reset.
REQ-007 id_valid  in  1  instruction present in ID.
REQ-008 id_src  in  NUM_SRC*REG_W  ID source register numbers, operand i at bits [i*REG_W +: REG_W].
REQ-009 id_src_used  in  NUM_SRC  per-operand "source actually read".
REQ-010 id_wn  in  REG_W  ID destination register.
REQ-011 id_we  in  1  ID instruction writes a register.
REQ-012 id_load  in  1  ID instruction is a memory load.
REQ-013 hold  in  1  external pipeline freeze.
REQ-014 flush  in  1  kill instruction entering EX.
REQ-015 stall  out  1  load-use stall; upstream keeps PC/IF/ID.
REQ-016 f_src  out  NUM_SRC*SEL_W  per-operand select for the EX instruction: 0 = register file, k = stage k.
REQ-017 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-018 SHALL hold an EX entry {valid, wn, we, load, src[], src_used[]} and producer entries P[1..DEPTH] {valid, wn, we}.
REQ-019 advance = !hold; on advance: P[k+1] <= P[k], P[1] <= EX producer fields, EX <= ID fields.
REQ-020 On advance with stall=1 or flush=1, EX SHALL load a bubble (valid=0); P still shifts.
REQ-021 On hold=1, P and EX SHALL keep their values, except flush=1 SHALL still clear EX.valid.
REQ-022 stall SHALL be combinational: id_valid & EX.valid & EX.we & EX.load & EX.wn!=0 & any i (id_src_used[i] & id_src[i]==EX.wn).
REQ-023 f_src[i] SHALL be combinational: the smallest k with P[k].valid & P[k].we & P[k].wn!=0 & P[k].wn==EX.src[i], qualified by EX.valid & EX.src_used[i]; otherwise 0.
REQ-024 The nearest stage SHALL win when several stages match; register 0 SHALL never forward.
REQ-025 An EX bubble SHALL yield f_src = 0 for all operands.
REQ-026 stall_cnt SHALL increment on each clock with stall=1 & !hold, and saturate at 16'hFFFF.
REQ-027 stall and f_src SHALL have zero-cycle latency from registered state; no output SHALL depend on f_src.

Reset
REQ-028 With rst=0 at a rising edge, EX.valid and all P[k].valid SHALL clear, stall_cnt SHALL be 0, and f_src and stall SHALL therefore be 0.
REQ-029 Reset SHALL override hold and flush; an in-flight stall SHALL be dropped.

Structure
REQ-030 SHALL place REG_W, the default DEPTH and NUM_SRC, and the select encoding (SEL_RF=0) in a shared pipeline package.
REQ-031 SHALL use one sub-module, fwd_match, instantiated NUM_SRC times: a priority match of one source against P[1..DEPTH].

Verification
REQ-032 add r3 then add r4,r3,r5 back-to-back, DEPTH=2 -> f_src[0]=1, f_src[1]=0 in the consumer's EX cycle.
REQ-033 add r3; nop; sub r6,r3,r3 -> f_src[0]=2, f_src[1]=2.
REQ-034 lw r2 then add r7,r2,r1 -> stall=1 for exactly one cycle, then f_src[0]=2, with stall_cnt going from 0 to 1.
REQ-035 add r0,... then or r8,r0,r0 -> f_src=0 and stall=0.
REQ-036 add r3 twice, then consumer of r3 -> f_src[0]=1 (nearest wins); hold=1 for 3 cycles mid-sequence -> f_src unchanged throughout.
REQ-037 lw r2 in EX, consumer in ID, flush=1 -> EX bubble, stall=0 next cycle; rst=0 mid-stall -> stall=0, stall_cnt=0.
